servo_bank_controller: RTL
==========================

SERVO_BANK_CONTROLLER -- requirements
Module: servo_bank_controller

Interface
REQ-001 Parameter NUM_CH, default 8: number of servo channels; range 1..16.
REQ-002 Parameter DUTY_W, default 8: duty word width.
REQ-003 Parameter FRAME_CYCLES, default 1_000_000: PWM frame length in clocks (20 ms at 50 MHz).
REQ-004 Parameter MIN_PULSE, default 50_000: pulse width for duty 0 (1 ms).
REQ-005 Parameter MAX_PULSE, default 100_000: pulse width ceiling (2 ms).
REQ-006 Parameter STEP_CYCLES, default 196: clocks added per duty LSB.
REQ-007 Parameter DUTY_RESET, default 128: per-channel duty after reset (neutral).
REQ-008 Parameter RAMP_STEP, default 4: maximum duty change per frame when ramping.
REQ-009 clock  input  1  system clock; one clock domain; all logic on its rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 channelselect  input  CSW=max(1,$clog2(NUM_CH))  channel index for the latch.
REQ-012 duty  input  DUTY_W  requested duty value.
REQ-013 latchbtn  input  1  active-low, asynchronous push-button; falling edge latches duty.
REQ-014 PWMOut  output  NUM_CH  per-channel servo pulse, registered.
REQ-015 frame_start  output  1  one-cycle pulse marking the first cycle of each frame, registered.
REQ-016 busy  output  1  high while any channel's active duty differs from its target, registered.

Function
REQ-017 latchbtn SHALL pass a 2-flop synchronizer; a falling edge is detected when sync stage 2 is 1 and stage 1 is 0.
REQ-018 On the detect cycle, target[channelselect] SHALL load duty; channelselect >= NUM_CH SHALL be ignored, with no write.
REQ-019 Latency from latchbtn falling (setup met) to target updated SHALL be 3 clocks; duty/channelselect are sampled in the detect cycle.
REQ-020 Frame counter SHALL count 0..FRAME_CYCLES-1 and wrap to 0.
REQ-021 At counter==0, each active[i] SHALL update from the target[i] value held in that cycle; a latch write in the same cycle takes effect one frame later.
REQ-022 pulse[i] SHALL equal min(MIN_PULSE + active[i]*STEP_CYCLES, MAX_PULSE), using arithmetic width >= $clog2(FRAME_CYCLES)+1 with no truncation.
REQ-023 PWMOut[i] SHALL be high for exactly pulse[i] consecutive clocks per frame, starting 1 clock after counter==0.
REQ-024 frame_start SHALL be high in the same cycle as the first high cycle of PWMOut.
REQ-025 pulse[i] >= FRAME_CYCLES SHALL produce a constant-high output; no glitch at the frame wrap.
REQ-026 Channels SHALL be independent; a write to one channel never alters another's pulse.

Reset
REQ-027 While reset is high: counter=0, target[i]=active[i]=DUTY_RESET, PWMOut=0, frame_start=0, busy=0, sync flops=1 (button released).
REQ-028 Reset asserted mid-frame SHALL drive PWMOut low on the next clock edge.
REQ-029 After reset deasserts, the first frame_start SHALL occur 1 clock later.
REQ-030 A latchbtn falling edge during reset SHALL be discarded.

Configuration
REQ-031 Macro SERVO_RAMP_EN defined: at each frame boundary, active[i] moves toward target[i] by min(RAMP_STEP, |target-active|).
REQ-032 SERVO_RAMP_EN undefined: active[i]=target[i] at each frame boundary; busy is high only between a write and the next boundary.

Verification
REQ-033 Reset, defaults, no ramp -> every PWMOut is high 75_088 clocks per 1_000_000-clock frame; frame_start has period 1_000_000.
REQ-034 Latch duty=8'hFF on ch0, no ramp -> ch0 pulse is 99_980 from the next frame; ch1..7 stay at 75_088.
REQ-035 SERVO_RAMP_EN, ch2 from DUTY_RESET 128 to 255 -> pulse grows 784 clocks per frame and reaches 99_980 after 32 frames; busy then drops.
REQ-036 NUM_CH=6, channelselect=7, latch -> no target changes and busy stays 0.
REQ-037 Latch landing on counter==0 -> old pulse in the current frame, new pulse in the following frame.
REQ-038 STEP_CYCLES=200, duty=255 -> pulse clamped to 100_000; reset asserted mid-pulse -> PWMOut=0 on the next cycle.

Source files
------------

// File: rtl/servo_bank_controller.sv
`default_nettype none
// ============================================================================
// Module  : servo_bank_controller
// Brief   : NUM_CH-channel servo PWM bank; a push-button latches a duty word
//           into one channel's target, applied at the next frame boundary.
//           Define SERVO_RAMP_EN to slew each channel by at most RAMP_STEP
//           duty LSBs per frame instead of jumping straight to the target.
// Rev     : 1.0 - initial release
// ============================================================================
module servo_bank_controller #(
    parameter int NUM_CH       = 8,
    parameter int DUTY_W       = 8,
    parameter int FRAME_CYCLES = 1_000_000,
    parameter int MIN_PULSE    = 50_000,
    parameter int MAX_PULSE    = 100_000,
    parameter int STEP_CYCLES  = 196,
    parameter int DUTY_RESET   = 128,
    parameter int RAMP_STEP    = 4,
    localparam int CSW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CSW-1:0]    channelselect,
    input  logic [DUTY_W-1:0] duty,
    input  logic              latchbtn,
    output logic [NUM_CH-1:0] PWMOut,
    output logic              frame_start,
    output logic              busy
);

`ifdef SERVO_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    // Without ramping the step limit exceeds any possible gap, so the
    // shared slew datapath degenerates to a direct load of the target.
    localparam int STEP_LIM = RAMP_EN ? RAMP_STEP : (1 << DUTY_W);
    localparam logic [DUTY_W:0] RAMP_C = (DUTY_W + 1)'(STEP_LIM);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    localparam longint RAW_MAX = longint'(MIN_PULSE)
                               + ((longint'(1) << DUTY_W) - 1) * longint'(STEP_CYCLES);
    localparam longint PEAK_A  = (RAW_MAX > longint'(MAX_PULSE)) ? RAW_MAX : longint'(MAX_PULSE);
    localparam longint PEAK    = (PEAK_A > longint'(FRAME_CYCLES)) ? PEAK_A : longint'(FRAME_CYCLES);
    localparam int PW          = $clog2(PEAK + 1) + 1;

    localparam logic [PW-1:0]     MAX_C      = PW'(MAX_PULSE);
    localparam logic [CSW:0]      CH_LIMIT   = (CSW + 1)'(NUM_CH);
    localparam logic [DUTY_W-1:0] DUTY_RST_C = DUTY_W'(DUTY_RESET);

    logic              sync1_q, sync2_q;
    logic [1:0]        arm_q, arm_d;
    logic              wr_en_q, wr_en_d;
    logic [CSW-1:0]    wr_ch_q, wr_ch_d;
    logic [DUTY_W-1:0] wr_duty_q, wr_duty_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              frame_start_q, frame_start_d;
    logic              busy_q, busy_d;

    logic [DUTY_W-1:0] target_q [NUM_CH];
    logic [DUTY_W-1:0] target_d [NUM_CH];
    logic [DUTY_W-1:0] active_q [NUM_CH];
    logic [DUTY_W-1:0] active_d [NUM_CH];

    logic [DUTY_W:0]   w_gap   [NUM_CH];
    logic [DUTY_W-1:0] w_step  [NUM_CH];
    logic [PW-1:0]     w_raw   [NUM_CH];
    logic [PW-1:0]     w_pulse [NUM_CH];
    logic              w_fall;
    logic              w_boundary;

    // arm_q masks the first two cycles after reset so a button already held
    // low while reset was asserted never registers as a fresh press.
    always_comb begin
        arm_d         = {arm_q[0], 1'b1};
        w_fall        = sync2_q & ~sync1_q & arm_q[1];
        wr_en_d       = w_fall & ({1'b0, channelselect} < CH_LIMIT);
        wr_ch_d       = channelselect;
        wr_duty_d     = duty;
        w_boundary    = (cnt_q == '0);
        cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        frame_start_d = w_boundary;
    end

    // The pulse compare uses active_d so that the boundary cycle already
    // sees this frame's duty; the first high output cycle is the one after it.
    always_comb begin
        busy_d = 1'b0;
        pwm_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            target_d[i] = target_q[i];
            if (wr_en_q && (wr_ch_q == CSW'(i))) begin
                target_d[i] = wr_duty_q;
            end
            if (target_q[i] >= active_q[i]) begin
                w_gap[i]  = {1'b0, target_q[i]} - {1'b0, active_q[i]};
                w_step[i] = (w_gap[i] > RAMP_C) ? active_q[i] + RAMP_C[DUTY_W-1:0] : target_q[i];
            end else begin
                w_gap[i]  = {1'b0, active_q[i]} - {1'b0, target_q[i]};
                w_step[i] = (w_gap[i] > RAMP_C) ? active_q[i] - RAMP_C[DUTY_W-1:0] : target_q[i];
            end
            active_d[i] = w_boundary ? w_step[i] : active_q[i];
            w_raw[i]    = PW'(MIN_PULSE) + PW'(active_d[i]) * PW'(STEP_CYCLES);
            w_pulse[i]  = (w_raw[i] > MAX_C) ? MAX_C : w_raw[i];
            pwm_d[i]    = (PW'(cnt_q) < w_pulse[i]);
            busy_d      = busy_d | (active_d[i] != target_d[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            arm_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_ch_q       <= '0;
            wr_duty_q     <= '0;
            cnt_q         <= '0;
            pwm_q         <= '0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= DUTY_RST_C;
                active_q[i] <= DUTY_RST_C;
            end
        end else begin
            sync1_q       <= latchbtn;
            sync2_q       <= sync1_q;
            arm_q         <= arm_d;
            wr_en_q       <= wr_en_d;
            wr_ch_q       <= wr_ch_d;
            wr_duty_q     <= wr_duty_d;
            cnt_q         <= cnt_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= target_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign PWMOut      = pwm_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire
